// File: rtl/step_ramp_gen.sv
// Trapezoidal step-rate generator: one-cycle step requests whose spacing ramps
// between START_PERIOD and MIN_PERIOD, with signed position tracking.
module step_ramp_gen #(
  parameter int unsigned PW           = 16,
  parameter int unsigned START_PERIOD = 3000,
  parameter int unsigned MIN_PERIOD   = 1500,
  parameter int unsigned RAMP_STEP    = 50,
  parameter int unsigned POS_W        = 24
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             EN,
  input  logic             DIR,
  input  logic             ZERO,
  output logic             SP,
  output logic             DIR_OUT,
  output logic             BUSY,
  output logic [POS_W-1:0] POS
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCEL  = 2'd1;
  localparam logic [1:0] S_CRUISE = 2'd2;
  localparam logic [1:0] S_DECEL  = 2'd3;

  localparam int unsigned PW1 = PW + 1;

  localparam logic [PW-1:0]  C_START   = PW'(START_PERIOD);
  localparam logic [PW-1:0]  C_MIN     = PW'(MIN_PERIOD);
  localparam logic [PW-1:0]  C_STEP    = PW'(RAMP_STEP);
  localparam logic [PW1-1:0] C_START_W = PW1'(START_PERIOD);
  localparam logic [PW1-1:0] C_STEP_W  = PW1'(RAMP_STEP);
  localparam logic [PW1-1:0] C_DEC_LIM = PW1'(MIN_PERIOD + RAMP_STEP);

  logic [1:0]       r_state;
  logic [PW-1:0]    r_period;
  logic [PW-1:0]    r_cnt;
  logic             r_stepped;
  logic             r_sp;
  logic             r_dir;
  logic             r_busy;
  logic [POS_W-1:0] r_pos;

  logic [1:0]       w_state_nxt;
  logic [PW-1:0]    w_period_nxt;
  logic [PW-1:0]    w_cnt_nxt;
  logic             w_stepped_nxt;
  logic             w_sp_nxt;
  logic             w_dir_nxt;

  logic             w_tick;
  logic             w_stop;
  logic [PW1-1:0]   w_per_up;
  logic [PW-1:0]    w_per_dn;

  assign w_tick   = (r_cnt == (r_period - PW'(1)));
  assign w_stop   = !EN || (DIR != r_dir);
  assign w_per_up = {1'b0, r_period} + C_STEP_W;
  // Saturating decrement: never dips below the cruise period, never underflows.
  assign w_per_dn = ({1'b0, r_period} >= C_DEC_LIM) ? (r_period - C_STEP) : C_MIN;

  // Next-state, interval and period-update logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_period_nxt  = r_period;
    w_cnt_nxt     = r_cnt + PW'(1);
    w_stepped_nxt = r_stepped;
    w_sp_nxt      = 1'b0;
    w_dir_nxt     = r_dir;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt     = '0;
        w_period_nxt  = C_START;
        w_stepped_nxt = 1'b0;
        if (EN) begin
          w_dir_nxt   = DIR;
          w_state_nxt = S_ACCEL;
        end
      end
      S_ACCEL, S_CRUISE: begin
        if (w_stop && !r_stepped && !w_tick) begin
          // Aborted before any step was issued: nothing to ramp down from.
          w_state_nxt  = S_IDLE;
          w_cnt_nxt    = '0;
          w_period_nxt = C_START;
        end else begin
          if (w_tick) begin
            w_sp_nxt      = 1'b1;
            w_cnt_nxt     = '0;
            w_stepped_nxt = 1'b1;
            if (r_state == S_ACCEL) begin
              w_period_nxt = w_per_dn;
            end
          end
          if (w_stop) begin
            w_state_nxt = S_DECEL;
          end else if (w_tick && (r_state == S_ACCEL) && (w_per_dn == C_MIN)) begin
            w_state_nxt = S_CRUISE;
          end
        end
      end
      S_DECEL: begin
        if (w_tick && (w_per_up >= C_START_W)) begin
          w_sp_nxt     = 1'b1;
          w_cnt_nxt    = '0;
          w_period_nxt = C_START;
          w_state_nxt  = S_IDLE;
        end else begin
          if (w_tick) begin
            w_sp_nxt     = 1'b1;
            w_cnt_nxt    = '0;
            w_period_nxt = w_per_up[PW-1:0];
          end
          if (!w_stop) begin
            w_state_nxt = S_ACCEL;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers; position follows the registered step pulse.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state   <= S_IDLE;
      r_period  <= C_START;
      r_cnt     <= '0;
      r_stepped <= 1'b0;
      r_sp      <= 1'b0;
      r_dir     <= 1'b0;
      r_busy    <= 1'b0;
      r_pos     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_period  <= w_period_nxt;
      r_cnt     <= w_cnt_nxt;
      r_stepped <= w_stepped_nxt;
      r_sp      <= w_sp_nxt;
      r_dir     <= w_dir_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      if (ZERO) begin
        r_pos <= '0;
      end else if (r_sp) begin
        r_pos <= r_dir ? (r_pos + POS_W'(1)) : (r_pos - POS_W'(1));
      end
    end
  end

  assign SP      = r_sp;
  assign DIR_OUT = r_dir;
  assign BUSY    = r_busy;
  assign POS     = r_pos;

endmodule

// File: tb/tb_step_ramp_gen.sv
// Scoreboard bench for step_ramp_gen: expected step gaps, direction and
// position are queued by the stimulus and checked by an independent monitor.
`timescale 1ns/1ps
module tb_step_ramp_gen;

  localparam int unsigned T_PW    = 16;
  localparam int unsigned T_START = 10;
  localparam int unsigned T_MIN   = 4;
  localparam int unsigned T_STEP  = 2;
  localparam int unsigned T_POSW  = 8;

  logic              CLK = 1'b0;
  logic              RSTn;
  logic              EN;
  logic              DIR;
  logic              ZERO;
  logic              SP;
  logic              DIR_OUT;
  logic              BUSY;
  logic [T_POSW-1:0] POS;

  typedef struct {
    int          gap;
    logic        dir;
    logic [7:0]  pos;
  } exp_t;

  exp_t       q[$];
  int         checks   = 0;
  int         failures = 0;
  int         sp_seen  = 0;
  logic [7:0] exp_pos  = 8'd0;

  step_ramp_gen #(
    .PW(T_PW), .START_PERIOD(T_START), .MIN_PERIOD(T_MIN),
    .RAMP_STEP(T_STEP), .POS_W(T_POSW)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .EN(EN), .DIR(DIR), .ZERO(ZERO),
    .SP(SP), .DIR_OUT(DIR_OUT), .BUSY(BUSY), .POS(POS)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic push(input int gap, input logic dir, input logic zero = 1'b0);
    exp_t e;
    if (zero)     exp_pos = 8'd0;
    else if (dir) exp_pos = exp_pos + 8'd1;
    else          exp_pos = exp_pos - 8'd1;
    e.gap = gap;
    e.dir = dir;
    e.pos = exp_pos;
    q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic wait_sp(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      #1;
      if (sp_seen >= n) return;
    end
    checks++;
    failures++;
    $display("FAIL timeout_step%0d actual=%0d required=%0d", n, sp_seen, n);
    summary();
    $finish;
  endtask

  // Monitor: measures gaps from the previous step (or move start) and pops expectations.
  initial begin : monitor
    int         gap;
    logic       prev_busy;
    logic       pend;
    logic [7:0] pend_pos;
    exp_t       e;
    gap = 0; prev_busy = 1'b0; pend = 1'b0; pend_pos = 8'd0;
    forever begin
      @(negedge CLK);
      if (!RSTn) begin
        gap = 0; pend = 1'b0; prev_busy = 1'b0;
      end else begin
        gap++;
        if (BUSY && !prev_busy) gap = 0;
        if (pend) begin
          check($sformatf("sp%0d_pos", sp_seen), int'(POS), int'(pend_pos));
          pend = 1'b0;
        end
        if (SP) begin
          sp_seen++;
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_sp%0d actual=step required=none", sp_seen);
          end else begin
            e = q.pop_front();
            check($sformatf("sp%0d_gap", sp_seen), gap, e.gap);
            check($sformatf("sp%0d_dir_out", sp_seen), int'(DIR_OUT), int'(e.dir));
            pend     = 1'b1;
            pend_pos = e.pos;
          end
          gap = 0;
        end
        prev_busy = BUSY;
      end
    end
  end

  initial begin : watchdog
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int base;
    int gap;
    RSTn = 1'b0; EN = 1'b0; DIR = 1'b0; ZERO = 1'b0;
    cycles(3);
    check("rst_sp", int'(SP), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_pos", int'(POS), 0);
    check("rst_dir_out", int'(DIR_OUT), 0);

    // Ramp up from reset and cruise.
    push(10, 1'b1); push(8, 1'b1); push(6, 1'b1);
    repeat (3) push(4, 1'b1);
    EN = 1'b1; DIR = 1'b1; RSTn = 1'b1;
    wait_sp(6, 200);
    check("s1_busy", int'(BUSY), 1);

    // Drop enable while cruising: 4 in progress, then 6, 8, stop.
    push(4, 1'b1); push(6, 1'b1); push(8, 1'b1);
    EN = 1'b0;
    wait_sp(9, 100);
    cycles(3);
    check("s2_busy", int'(BUSY), 0);
    check("s2_pos", int'(POS), 9);

    // Reversal while cruising forward.
    push(10, 1'b1); push(8, 1'b1); push(6, 1'b1); push(4, 1'b1); push(4, 1'b1);
    EN = 1'b1;
    wait_sp(14, 200);
    push(4, 1'b1); push(6, 1'b1); push(8, 1'b1);
    push(10, 1'b0); push(8, 1'b0); push(6, 1'b0); push(4, 1'b0);
    DIR = 1'b0;
    wait_sp(17, 100);
    check("s3_idle_busy", int'(BUSY), 0);
    check("s3_idle_dir_out", int'(DIR_OUT), 1);
    cycles(1);
    check("s3_relatch_dir_out", int'(DIR_OUT), 0);
    check("s3_relatch_busy", int'(BUSY), 1);
    wait_sp(21, 200);

    // Stop the reverse move, then a short enable pulse that issues no step.
    push(4, 1'b0); push(6, 1'b0); push(8, 1'b0);
    EN = 1'b0;
    wait_sp(24, 100);
    cycles(3);
    check("s4_pos_before", int'(POS), int'(exp_pos));
    DIR = 1'b1; EN = 1'b1;
    cycles(3);
    check("s4_pulse_busy", int'(BUSY), 1);
    cycles(2);
    EN = 1'b0;
    cycles(2);
    check("s4_after_busy", int'(BUSY), 0);
    check("s4_after_pos", int'(POS), int'(exp_pos));
    check("s4_no_sp", sp_seen, 24);
    check("s4_dir_out", int'(DIR_OUT), 1);

    // Position clear, signed boundary 0x7F -> 0x80, clear colliding with a step.
    ZERO = 1'b1;
    cycles(1);
    ZERO = 1'b0;
    exp_pos = 8'd0;
    check("s5_zero_idle", int'(POS), 0);
    base = sp_seen;
    for (int k = 1; k <= 131; k++) begin
      gap = (k == 1) ? 10 : (k == 2) ? 8 : (k == 3) ? 6 : 4;
      push(gap, 1'b1, (k == 129));
    end
    EN = 1'b1;
    wait_sp(base + 127, 1000);
    cycles(1);
    check("s5_pos_0x7f", int'(POS), 8'h7F);
    wait_sp(base + 128, 100);
    cycles(1);
    check("s5_pos_0x80", int'(POS), 8'h80);
    wait_sp(base + 129, 100);
    ZERO = 1'b1;
    cycles(1);
    ZERO = 1'b0;
    check("s5_zero_wins", int'(POS), 0);

    // Asynchronous reset in the middle of a step pulse.
    wait_sp(base + 131, 100);
    RSTn = 1'b0;
    #1;
    check("s6_rst_sp", int'(SP), 0);
    check("s6_rst_busy", int'(BUSY), 0);
    check("s6_rst_pos", int'(POS), 0);
    check("s6_rst_dir_out", int'(DIR_OUT), 0);
    cycles(2);
    exp_pos = 8'd0;
    push(10, 1'b1); push(8, 1'b1);
    RSTn = 1'b1;
    wait_sp(base + 133, 200);
    cycles(2);
    check("end_queue_empty", q.size(), 0);
    summary();
    $finish;
  end

endmodule

// File: doc/step_ramp_gen.md
Name: step_ramp_gen

Overview:
- Step-rate generator with trapezoidal acceleration/deceleration; replaces the fixed-rate step-request source feeding the step pulse shaper.
- Consumes run enable and direction from the direction/enable controller.
- Emits one-cycle step requests (SP) whose spacing ramps between a start period and a minimum period.
- Tracks signed absolute position and protects direction reversals: ramp down to stop, latch new direction, ramp up again.

Parameters:
- PW, 16: width of period and interval counters.
- START_PERIOD, 3000: interval in CLK cycles for first and last step of a move (slowest rate).
- MIN_PERIOD, 1500: cruise interval (fastest rate); 2 <= MIN_PERIOD <= START_PERIOD < 2^PW.
- RAMP_STEP, 50: period change applied per step during a ramp; >= 1.
- POS_W, 24: position counter width.

Ports:
- CLK  in  1  system clock.
- RSTn  in  1  asynchronous active-low reset.
- EN  in  1  run request, synchronous to CLK, level.
- DIR  in  1  requested direction (1 = forward, 0 = reverse), synchronous to CLK.
- ZERO  in  1  synchronous position clear.
- SP  out  1  step request, one CLK cycle wide, registered.
- DIR_OUT  out  1  latched direction actually in use, registered.
- BUSY  out  1  high whenever state != IDLE.
- POS  out  POS_W  signed step position, two's complement.

Behaviour:
- Reset (async, RSTn=0) values:
  - state = IDLE, period = START_PERIOD, cnt = 0.
  - SP = 0, DIR_OUT = 0, BUSY = 0, POS = 0.
- States: IDLE, ACCEL, CRUISE, DECEL.
- Stop condition: EN = 0, or DIR != DIR_OUT.
- IDLE:
  - cnt = 0, period = START_PERIOD.
  - If EN = 1: latch DIR_OUT <= DIR and go to ACCEL on the next edge.
- Interval timing, in ACCEL/CRUISE/DECEL:
  - cnt increments each cycle.
  - When cnt == period-1: SP = 1 for exactly one cycle and cnt <= 0. First SP of a move is START_PERIOD cycles after entry to ACCEL.
- Period update on each SP:
  - ACCEL: period <= max(period - RAMP_STEP, MIN_PERIOD), saturating with no underflow. If the new value == MIN_PERIOD, go to CRUISE.
  - CRUISE: period held.
  - DECEL: if period + RAMP_STEP >= START_PERIOD, go to IDLE (this SP is the last step) and period <= START_PERIOD; else period <= period + RAMP_STEP. Compute the sum PW+1 wide.
- Stop condition in ACCEL or CRUISE:
  - Before the first SP of the move (period == START_PERIOD and no SP yet): go to IDLE immediately, no SP emitted.
  - Otherwise go to DECEL. The interval in progress completes at its current period.
- DECEL with EN = 1 and DIR == DIR_OUT: return to ACCEL. Ramp resumes from the current period; cnt is not reset.
- Direction reversal:
  - DIR_OUT changes only in IDLE.
  - A pending reversal with EN = 1 restarts the move one cycle after IDLE is reached.
- If START_PERIOD == MIN_PERIOD: the first SP moves ACCEL to CRUISE. Decel ends on the first SP after entering DECEL.
- POS:
  - On SP: POS <= POS + 1 if DIR_OUT = 1, else POS - 1. Wraps modulo 2^POS_W.
  - ZERO = 1 forces POS <= 0. ZERO wins over a simultaneous SP (result 0).
- Simultaneous SP and stop condition: the period update uses the state before the transition. The SP is counted in POS.
- RSTn asserted mid-move: all state returns to reset values asynchronously. SP deasserts immediately.

Test Plan (START_PERIOD=10, MIN_PERIOD=4, RAMP_STEP=2, POS_W=8):
1. Reset release, EN=1, DIR=1 held → SP at 10, 8, 6 cycles apart, then every 4 cycles; BUSY=1; POS counts 1, 2, 3…
2. Cruise at 4, then drop EN → SP gaps 4 (interval in progress), 6, 8; then BUSY=0, state IDLE; POS advances by exactly 3 more.
3. Cruising DIR=1, toggle DIR to 0 with EN=1 → decel as in scenario 2; DIR_OUT flips to 0 one cycle after IDLE; new ramp 10, 8, 6, 4; POS decrements.
4. EN pulsed high for 5 cycles from IDLE → no SP, BUSY high for the pulse and returns to 0, POS unchanged.
5. POS = 0x7F with DIR_OUT=1, one SP → POS = 0x80. Assert ZERO on the same cycle as an SP → POS = 0.
6. Assert RSTn=0 mid-cruise → SP, BUSY, POS, DIR_OUT all 0 at once. After release with EN=1, first SP arrives 10 cycles after ACCEL entry.
